// File: rtl/pipe_control_if.sv
// Control-path bundle between the ID-stage decode inputs
// and the per-stage control outputs of pipe_control.
interface pipe_control_if #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
);
    logic [OP_W-1:0]    op;
    logic               id_valid;
    logic               stall;
    logic               flush;
    logic               jump_id;
    logic               ex_valid;
    logic               ex_reg_dst;
    logic               ex_alu_src;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic               mem_valid;
    logic               mem_branch;
    logic               mem_branch_ne;
    logic               mem_mem_read;
    logic               mem_mem_write;
    logic               wb_valid;
    logic               wb_reg_write;
    logic               wb_mem_to_reg;
    logic               illegal_op;

    modport master (
        output op, id_valid, stall, flush,
        input  jump_id,
        input  ex_valid, ex_reg_dst, ex_alu_src, ex_alu_op,
        input  mem_valid, mem_branch, mem_branch_ne,
        input  mem_mem_read, mem_mem_write,
        input  wb_valid, wb_reg_write, wb_mem_to_reg,
        input  illegal_op
    );

    modport slave (
        input  op, id_valid, stall, flush,
        output jump_id,
        output ex_valid, ex_reg_dst, ex_alu_src, ex_alu_op,
        output mem_valid, mem_branch, mem_branch_ne,
        output mem_mem_read, mem_mem_write,
        output wb_valid, wb_reg_write, wb_mem_to_reg,
        output illegal_op
    );
endinterface

// File: rtl/pipe_control.sv
// Pipelined MIPS main control: decodes the ID opcode and carries
// the control bundle through ID/EX, EX/MEM and MEM/WB registers.
module pipe_control #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input logic         clk,
    input logic         rst,
    pipe_control_if.slave bus
);
    typedef struct packed {
        logic               valid;
        logic               regDst;
        logic               aluSrc;
        logic [ALUOP_W-1:0] aluOp;
        logic               branch;
        logic               branchNe;
        logic               memRead;
        logic               memWrite;
        logic               regWrite;
        logic               memToReg;
    } ctrl_t;

    ctrl_t      dec;
    ctrl_t      exQ;
    ctrl_t      memQ;
    ctrl_t      wbQ;
    logic       legal;
    logic       illegalQ;
    logic [5:0] op6;

    assign op6 = bus.op[5:0];

    always_comb begin
        dec   = '0;
        legal = ((bus.op >> 6) == '0);
        dec.valid = 1'b1;
        unique case (op6)
            6'd0: begin
                dec.regDst   = 1'b1;
                dec.regWrite = 1'b1;
                dec.aluOp    = ALUOP_W'(3'b010);
            end
            6'd2: ;
            6'd4: begin
                dec.branch = 1'b1;
                dec.aluOp  = ALUOP_W'(3'b001);
            end
            6'd5: begin
                dec.branch   = 1'b1;
                dec.branchNe = 1'b1;
                dec.aluOp    = ALUOP_W'(3'b001);
            end
            6'd8: begin
                dec.aluSrc   = 1'b1;
                dec.regWrite = 1'b1;
            end
            6'd10: begin
                dec.aluSrc   = 1'b1;
                dec.regWrite = 1'b1;
                dec.aluOp    = ALUOP_W'(3'b101);
            end
            6'd12: begin
                dec.aluSrc   = 1'b1;
                dec.regWrite = 1'b1;
                dec.aluOp    = ALUOP_W'(3'b100);
            end
            6'd13: begin
                dec.aluSrc   = 1'b1;
                dec.regWrite = 1'b1;
                dec.aluOp    = ALUOP_W'(3'b011);
            end
            6'd15: begin
                dec.aluSrc   = 1'b1;
                dec.regWrite = 1'b1;
                dec.aluOp    = ALUOP_W'(3'b110);
            end
            6'd35: begin
                dec.aluSrc   = 1'b1;
                dec.memRead  = 1'b1;
                dec.memToReg = 1'b1;
                dec.regWrite = 1'b1;
            end
            6'd43: begin
                dec.aluSrc   = 1'b1;
                dec.memWrite = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Flush and stall outrank the illegal-op trap, so a killed or
    // held op never sets the sticky flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            exQ      <= '0;
            memQ     <= '0;
            wbQ      <= '0;
            illegalQ <= 1'b0;
        end else begin
            wbQ  <= memQ;
            memQ <= bus.flush ? '0 : exQ;
            if (bus.flush || bus.stall || !bus.id_valid) begin
                exQ <= '0;
            end else if (!legal) begin
                exQ      <= '0;
                illegalQ <= 1'b1;
            end else begin
                exQ <= dec;
            end
        end
    end

    assign bus.jump_id       = bus.id_valid && (bus.op == OP_W'(2));
    assign bus.ex_valid      = exQ.valid;
    assign bus.ex_reg_dst    = exQ.regDst;
    assign bus.ex_alu_src    = exQ.aluSrc;
    assign bus.ex_alu_op     = exQ.aluOp;
    assign bus.mem_valid     = memQ.valid;
    assign bus.mem_branch    = memQ.branch;
    assign bus.mem_branch_ne = memQ.branchNe;
    assign bus.mem_mem_read  = memQ.memRead;
    assign bus.mem_mem_write = memQ.memWrite;
    assign bus.wb_valid      = wbQ.valid;
    assign bus.wb_reg_write  = wbQ.regWrite;
    assign bus.wb_mem_to_reg = wbQ.memToReg;
    assign bus.illegal_op    = illegalQ;
endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: a reference pipeline model
// pushes expected outputs per edge; a monitor pops and compares.
module tb_pipe_control;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_control_if #(.OP_W(6), .ALUOP_W(3)) bus ();

    pipe_control #(.OP_W(6), .ALUOP_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passCnt  = 0;
    int totalCnt = 0;

    // [11]valid [10]regDst [9]aluSrc [8:6]aluOp [5]branch
    // [4]branchNe [3]memRead [2]memWrite [1]regWrite [0]memToReg
    logic [11:0] mEx, mMem, mWb;
    logic        mIll;
    logic [14:0] expQ[$];
    logic [14:0] sbExp;
    logic [14:0] obsVec;

    assign obsVec = {bus.ex_valid, bus.ex_reg_dst, bus.ex_alu_src,
                     bus.ex_alu_op,
                     bus.mem_valid, bus.mem_branch, bus.mem_branch_ne,
                     bus.mem_mem_read, bus.mem_mem_write,
                     bus.wb_valid, bus.wb_reg_write, bus.wb_mem_to_reg,
                     bus.illegal_op};

    function automatic logic [12:0] refDec(input logic [5:0] o);
        logic [11:0] c;
        logic        ok;
        ok = 1'b1;
        case (o)
            6'd0:  c = 12'b1_1_0_010_0000_10;
            6'd2:  c = 12'b1_0_0_000_0000_00;
            6'd4:  c = 12'b1_0_0_001_1000_00;
            6'd5:  c = 12'b1_0_0_001_1100_00;
            6'd8:  c = 12'b1_0_1_000_0000_10;
            6'd10: c = 12'b1_0_1_101_0000_10;
            6'd12: c = 12'b1_0_1_100_0000_10;
            6'd13: c = 12'b1_0_1_011_0000_10;
            6'd15: c = 12'b1_0_1_110_0000_10;
            6'd35: c = 12'b1_0_1_000_0010_11;
            6'd43: c = 12'b1_0_1_000_0001_00;
            default: begin
                c  = 12'b0;
                ok = 1'b0;
            end
        endcase
        return {ok, c};
    endfunction

    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            sbExp = expQ.pop_front();
            totalCnt++;
            if (obsVec !== sbExp)
                $display("FAIL scoreboard t=%0t got=%b want=%b",
                         $time, obsVec, sbExp);
            else
                passCnt++;
        end
    end

    task automatic cyc(input logic [5:0] o, input logic v,
                       input logic st, input logic fl,
                       input logic r);
        logic [12:0] d;
        bus.op       = o;
        bus.id_valid = v;
        bus.stall    = st;
        bus.flush    = fl;
        rst          = r;
        d = refDec(o);
        if (r) begin
            mEx = '0; mMem = '0; mWb = '0; mIll = 1'b0;
        end else begin
            mWb  = mMem;
            mMem = fl ? 12'b0 : mEx;
            if (fl || st || !v)
                mEx = '0;
            else if (!d[12]) begin
                mEx  = '0;
                mIll = 1'b1;
            end else
                mEx = d[11:0];
        end
        expQ.push_back({mEx[11:6], mMem[11], mMem[5:2],
                        mWb[11], mWb[1:0], mIll});
        @(posedge clk);
        #3;
    endtask

    task automatic test_reset();
        cyc(6'd35, 1, 0, 0, 0);
        cyc(6'd0,  1, 0, 0, 0);
        cyc(6'd63, 1, 0, 0, 0);
        cyc(6'd5,  1, 0, 0, 1);
        totalCnt++;
        if (obsVec !== 15'b0 || bus.illegal_op !== 1'b0)
            $display("FAIL reset_all_zero got=%b want=0", obsVec);
        else
            passCnt++;
    endtask

    task automatic test_back_to_back();
        cyc(6'd35, 1, 0, 0, 0);
        totalCnt++;
        if ({bus.ex_alu_src, bus.ex_alu_op} !== 4'b1000)
            $display("FAIL lw_ex got=%b want=1000",
                     {bus.ex_alu_src, bus.ex_alu_op});
        else
            passCnt++;
        cyc(6'd43, 1, 0, 0, 0);
        totalCnt++;
        if (bus.mem_mem_read !== 1'b1)
            $display("FAIL lw_mem_read got=%b want=1", bus.mem_mem_read);
        else
            passCnt++;
        cyc(6'd0, 1, 0, 0, 0);
        totalCnt++;
        if ({bus.wb_mem_to_reg, bus.wb_reg_write} !== 2'b11)
            $display("FAIL lw_wb got=%b want=11",
                     {bus.wb_mem_to_reg, bus.wb_reg_write});
        else
            passCnt++;
        cyc(6'd5, 1, 0, 0, 0);
        cyc(6'd8, 0, 0, 0, 0);
        totalCnt++;
        if ({bus.mem_branch, bus.mem_branch_ne} !== 2'b11)
            $display("FAIL bne_mem got=%b want=11",
                     {bus.mem_branch, bus.mem_branch_ne});
        else
            passCnt++;
        cyc(6'd10, 1, 0, 0, 0);
        cyc(6'd12, 1, 0, 0, 0);
        cyc(6'd4,  1, 0, 0, 0);
        cyc(6'd13, 1, 0, 0, 0);
    endtask

    task automatic test_stall();
        cyc(6'd0,  1, 0, 0, 0);
        cyc(6'd15, 1, 1, 0, 0);
        totalCnt++;
        if (bus.ex_valid !== 1'b0 || bus.mem_valid !== 1'b1)
            $display("FAIL stall1 got=%b%b want=01",
                     bus.ex_valid, bus.mem_valid);
        else
            passCnt++;
        cyc(6'd15, 1, 1, 0, 0);
        totalCnt++;
        if (bus.ex_valid !== 1'b0)
            $display("FAIL stall2 got=%b want=0", bus.ex_valid);
        else
            passCnt++;
        cyc(6'd15, 1, 0, 0, 0);
        totalCnt++;
        if ({bus.ex_valid, bus.ex_alu_op} !== 4'b1110)
            $display("FAIL stall_release got=%b want=1110",
                     {bus.ex_valid, bus.ex_alu_op});
        else
            passCnt++;
    endtask

    task automatic test_flush();
        cyc(6'd43, 1, 0, 0, 0);
        cyc(6'd8,  1, 0, 0, 0);
        cyc(6'd13, 1, 1, 1, 0);
        totalCnt++;
        if ({bus.ex_valid, bus.mem_valid, bus.wb_valid,
             bus.wb_reg_write} !== 4'b0010)
            $display("FAIL flush got=%b want=0010",
                     {bus.ex_valid, bus.mem_valid, bus.wb_valid,
                      bus.wb_reg_write});
        else
            passCnt++;
        cyc(6'd35, 1, 0, 0, 0);
        cyc(6'd0,  1, 0, 1, 0);
    endtask

    task automatic test_illegal();
        cyc(6'd63, 1, 1, 0, 0);
        totalCnt++;
        if (bus.illegal_op !== 1'b0)
            $display("FAIL illegal_stall got=%b want=0", bus.illegal_op);
        else
            passCnt++;
        cyc(6'd63, 1, 0, 1, 0);
        cyc(6'd63, 1, 0, 0, 0);
        totalCnt++;
        if ({bus.ex_valid, bus.illegal_op} !== 2'b01)
            $display("FAIL illegal_set got=%b want=01",
                     {bus.ex_valid, bus.illegal_op});
        else
            passCnt++;
        cyc(6'd0, 1, 0, 0, 0);
        cyc(6'd1, 1, 0, 0, 0);
        cyc(6'd35, 1, 0, 0, 0);
        totalCnt++;
        if (bus.illegal_op !== 1'b1)
            $display("FAIL illegal_sticky got=%b want=1", bus.illegal_op);
        else
            passCnt++;
        cyc(6'd0, 0, 0, 0, 1);
    endtask

    task automatic test_jump();
        bus.op = 6'd2; bus.id_valid = 1'b1;
        bus.stall = 1'b1; bus.flush = 1'b1;
        #1;
        totalCnt++;
        if (bus.jump_id !== 1'b1)
            $display("FAIL jump_id_gated got=%b want=1", bus.jump_id);
        else
            passCnt++;
        bus.id_valid = 1'b0;
        #1;
        totalCnt++;
        if (bus.jump_id !== 1'b0)
            $display("FAIL jump_id_invalid got=%b want=0", bus.jump_id);
        else
            passCnt++;
        cyc(6'd2, 1, 0, 0, 0);
        totalCnt++;
        if ({bus.ex_valid, bus.ex_reg_dst, bus.ex_alu_src,
             bus.ex_alu_op} !== 6'b100000)
            $display("FAIL jump_ex got=%b want=100000",
                     {bus.ex_valid, bus.ex_reg_dst, bus.ex_alu_src,
                      bus.ex_alu_op});
        else
            passCnt++;
        cyc(6'd0, 0, 0, 0, 0);
        cyc(6'd0, 0, 0, 0, 0);
        cyc(6'd0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.op = '0; bus.id_valid = 1'b0;
        bus.stall = 1'b0; bus.flush = 1'b0;
        mEx = '0; mMem = '0; mWb = '0; mIll = 1'b0;
        cyc(6'd0, 0, 0, 0, 1);
        test_reset();
        test_back_to_back();
        test_stall();
        test_flush();
        test_illegal();
        test_jump();
        @(posedge clk);
        #3;
        if (expQ.size() != 0) begin
            totalCnt++;
            $display("FAIL scoreboard_drain left=%0d want=0", expQ.size());
        end
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
